// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU/debug single-port memory arbiter.
package mem_arbiter_pkg;
    localparam int unsigned ADDRESS_LENGTH_DEF = 11;
    localparam int unsigned DATA_LENGTH_DEF    = 16;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } requester_e;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of CPU, debug and memory-side signals around mem_arbiter.
// slave: arbiter view; master: requester/memory environment view.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDRESS_LENGTH = ADDRESS_LENGTH_DEF,
    parameter int unsigned DATA_LENGTH    = DATA_LENGTH_DEF
) ();
    logic                      cpu_req;
    logic                      cpu_we;
    logic [ADDRESS_LENGTH-1:0] cpu_addr;
    logic [DATA_LENGTH-1:0]    cpu_wdata;
    logic                      cpu_gnt;
    logic                      cpu_rvalid;
    logic [DATA_LENGTH-1:0]    cpu_rdata;
    logic [15:0]               cpu_stall_cnt;

    logic                      dbg_req;
    logic                      dbg_we;
    logic [ADDRESS_LENGTH-1:0] dbg_addr;
    logic [DATA_LENGTH-1:0]    dbg_wdata;
    logic                      dbg_gnt;
    logic                      dbg_rvalid;
    logic [DATA_LENGTH-1:0]    dbg_rdata;
    logic                      dbg_lock;

    logic                      mem_en;
    logic                      mem_we;
    logic [ADDRESS_LENGTH-1:0] mem_addr;
    logic [DATA_LENGTH-1:0]    mem_wdata;
    logic [DATA_LENGTH-1:0]    mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall_cnt,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall_cnt,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, debug) arbiter for a single-port memory with debug lock.
// MEM_ARBITER_ROUND_ROBIN_EN: conflicts alternate; otherwise the CPU always wins.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDRESS_LENGTH = ADDRESS_LENGTH_DEF,
    parameter int unsigned DATA_LENGTH    = DATA_LENGTH_DEF
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    state_e     state_q, state_d;
    requester_e last_winner_q, last_winner_d;
    requester_e rd_tag_q, rd_tag_d;
    logic       rd_pend_q, rd_pend_d;
    logic [15:0] stall_q, stall_d;

    logic                      cpu_gnt;
    logic                      dbg_gnt;
    logic                      conflict_dbg_wins;
    logic                      we_sel;
    logic [ADDRESS_LENGTH-1:0] addr_sel;
    logic [DATA_LENGTH-1:0]    wdata_sel;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    assign conflict_dbg_wins = (last_winner_q == REQ_CPU);
`else
    logic unused_last_winner;
    assign conflict_dbg_wins  = 1'b0;
    assign unused_last_winner = last_winner_q;
`endif

    always_comb begin
        cpu_gnt       = 1'b0;
        dbg_gnt       = 1'b0;
        state_d       = state_q;
        last_winner_d = last_winner_q;

        // Grants are combinational from req, so they are forced low while reset is held.
        if (!reset) begin
            if (state_q == ST_LOCKED) begin
                dbg_gnt = bus.dbg_req;
                if (!bus.dbg_lock) state_d = ST_OPEN;
            end else begin
                if (bus.cpu_req && bus.dbg_req) begin
                    dbg_gnt = conflict_dbg_wins;
                    cpu_gnt = !conflict_dbg_wins;
                end else begin
                    cpu_gnt = bus.cpu_req;
                    dbg_gnt = bus.dbg_req;
                end
                if (dbg_gnt && bus.dbg_lock) state_d = ST_LOCKED;
            end
        end

        if (cpu_gnt)      last_winner_d = REQ_CPU;
        else if (dbg_gnt) last_winner_d = REQ_DBG;
    end

    always_comb begin
        we_sel    = dbg_gnt ? bus.dbg_we    : bus.cpu_we;
        addr_sel  = dbg_gnt ? bus.dbg_addr  : bus.cpu_addr;
        wdata_sel = dbg_gnt ? bus.dbg_wdata : bus.cpu_wdata;

        rd_pend_d = (cpu_gnt && !bus.cpu_we) || (dbg_gnt && !bus.dbg_we);
        rd_tag_d  = dbg_gnt ? REQ_DBG : REQ_CPU;

        stall_d = stall_q;
        if (bus.cpu_req && !cpu_gnt && (stall_q != '1)) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_OPEN;
            last_winner_q <= REQ_DBG;
            rd_tag_q      <= REQ_CPU;
            rd_pend_q     <= 1'b0;
            stall_q       <= '0;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            rd_tag_q      <= rd_tag_d;
            rd_pend_q     <= rd_pend_d;
            stall_q       <= stall_d;
        end
    end

    assign bus.cpu_gnt       = cpu_gnt;
    assign bus.dbg_gnt       = dbg_gnt;
    assign bus.mem_en        = cpu_gnt | dbg_gnt;
    assign bus.mem_we        = (cpu_gnt | dbg_gnt) & we_sel;
    assign bus.mem_addr      = addr_sel;
    assign bus.mem_wdata     = wdata_sel;
    assign bus.cpu_rvalid    = rd_pend_q && (rd_tag_q == REQ_CPU);
    assign bus.dbg_rvalid    = rd_pend_q && (rd_tag_q == REQ_DBG);
    assign bus.cpu_rdata     = bus.mem_rdata;
    assign bus.dbg_rdata     = bus.mem_rdata;
    assign bus.cpu_stall_cnt = stall_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDRESS_LENGTH, default 11, data memory address width.
REQ-002 Parameter DATA_LENGTH, default 16, data memory word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cpu_req / cpu_we  input  1 each  CPU access request / write enable (1=write, 0=read).
REQ-006 cpu_addr  input  ADDRESS_LENGTH; cpu_wdata  input  DATA_LENGTH  CPU address / write data.
REQ-007 cpu_gnt  output  1  CPU access accepted this cycle.
REQ-008 cpu_rvalid  output  1; cpu_rdata  output  DATA_LENGTH  CPU read-data return.
REQ-009 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata  same widths and meanings for the debug requester.
REQ-010 dbg_lock  input  1  debug holds memory ownership across consecutive accesses.
REQ-011 mem_en, mem_we  output  1 each; mem_addr  output  ADDRESS_LENGTH; mem_wdata  output  DATA_LENGTH  single-port memory command.
REQ-012 mem_rdata  input  DATA_LENGTH  memory read data, valid one cycle after mem_en with mem_we=0.
REQ-013 cpu_stall_cnt  output  16  cycles the CPU request has been refused.

Function
REQ-014 Exactly one access per cycle; at most one of cpu_gnt, dbg_gnt is high in any cycle.
REQ-015 Grant is combinational from current req inputs and registered state; a requester holds req and its fields stable until it sees gnt.
REQ-016 In the grant cycle mem_en=1 and mem_we/mem_addr/mem_wdata equal the winner's fields; no grant -> mem_en=0, mem_we=0.
REQ-017 Read latency 1: the cycle after a granted read, winner's rvalid=1 and rdata=mem_rdata; rvalid=0 otherwise, including after writes.
REQ-018 Back-to-back grants to the same or alternating requesters are allowed every cycle.
REQ-019 Only one requester active -> it is granted, same cycle.
REQ-020 FSM states OPEN and LOCKED; OPEN->LOCKED when dbg granted with dbg_lock=1; LOCKED->OPEN on the first edge with dbg_lock=0.
REQ-021 In LOCKED cpu_gnt=0 regardless of dbg_req; dbg_req is granted immediately.
REQ-022 last_winner register updated to the grantee on every grant.
REQ-023 cpu_stall_cnt increments each cycle with cpu_req=1 and cpu_gnt=0, saturates at 16'hFFFF, never wraps.

Reset
REQ-024 Reset asserted: state OPEN, last_winner=DBG, cpu_stall_cnt=0, both rvalid=0, all gnt and mem_en low.
REQ-025 Reset during an outstanding read discards the pending rvalid; no rvalid after reset release.

Configuration
REQ-026 Macro MEM_ARBITER_ROUND_ROBIN_EN defined: on a conflict in OPEN the requester not equal to last_winner wins.
REQ-027 Macro undefined: on a conflict in OPEN the CPU always wins; last_winner is still maintained but unused.

Structure
REQ-028 Shared package holds ADDRESS_LENGTH/DATA_LENGTH defaults, requester encoding (CPU=0, DBG=1), FSM state encoding.
REQ-029 Single module; no sub-module; read-return routing is a one-bit registered winner tag plus registered read flag.

Verification
REQ-030 CPU read only, addr 11'h005, mem word 16'hABCD -> cpu_gnt same cycle, cpu_rvalid next cycle with cpu_rdata=16'hABCD, dbg_rvalid=0.
REQ-031 Both req every cycle for 4 cycles, round-robin enabled -> grants CPU,DBG,CPU,DBG; cpu_stall_cnt=2.
REQ-032 Same stimulus, macro undefined -> 4 CPU grants, dbg_gnt=0, cpu_stall_cnt=0.
REQ-033 dbg_lock=1 with 3 debug reads while cpu_req=1 -> cpu_gnt=0 for those cycles, cpu_stall_cnt=3; CPU granted first cycle after dbg_lock drops.
REQ-034 Reset asserted the cycle after a granted CPU read -> cpu_rvalid stays 0, all outputs at reset values, stall count 0.
REQ-035 cpu_req held high, debug locked for 70000 cycles -> cpu_stall_cnt stops at 16'hFFFF.
